// File: rtl/inst_encoder.sv
// RV32I instruction encoder: packs decoded fields and a sign-extended
// immediate into a 32-bit instruction word, flags immediates that do not
// fit the selected format, and buffers {err, word} in a small FIFO.
module inst_encoder #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_mode,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imme,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instruction,
  output logic        out_err,
  output logic [15:0] enc_count,
  output logic [7:0]  err_count
);

  localparam logic [2:0] TYPE_R = 3'b000;
  localparam logic [2:0] TYPE_I = 3'b001;
  localparam logic [2:0] TYPE_S = 3'b010;
  localparam logic [2:0] TYPE_B = 3'b011;
  localparam logic [2:0] TYPE_U = 3'b100;
  localparam logic [2:0] TYPE_J = 3'b101;

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  // Returns {err, word}. Illegal immediates still produce the truncated
  // encoding so the generator can inspect what would have been emitted.
  function automatic logic [32:0] encode_word(
    input logic [2:0]  mode,
    input logic [6:0]  opcode,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [2:0]  funct3,
    input logic [6:0]  funct7,
    input logic [31:0] imm
  );
    logic [31:0] w;
    logic        e;
    w = '0;
    e = 1'b0;
    case (mode)
      TYPE_R: begin
        w = {funct7, rs2, rs1, funct3, rd, opcode};
      end
      TYPE_I: begin
        w = {imm[11:0], rs1, funct3, rd, opcode};
        e = (imm[31:11] != {21{imm[11]}});
      end
      TYPE_S: begin
        w = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        e = (imm[31:11] != {21{imm[11]}});
      end
      TYPE_B: begin
        w = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        e = (imm[31:12] != {20{imm[12]}}) || imm[0];
      end
      TYPE_U: begin
        w = {imm[31:12], rd, opcode};
        e = (imm[11:0] != 12'd0);
      end
      TYPE_J: begin
        w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        e = (imm[31:20] != {12{imm[20]}}) || imm[0];
      end
      default: begin
        w = '0;
        e = 1'b1;
      end
    endcase
    return {e, w};
  endfunction

  // Saturating 8-bit increment for the error counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [32:0]   enc_p0;
  logic [32:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  // Encode stage: combinational into the FIFO write port
  assign enc_p0 = encode_word(in_mode, in_opcode, in_rd, in_rs1, in_rs2,
                              in_funct3, in_funct7, in_imme);

  assign in_ready  = rst_n && !flush && (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_instruction = out_valid ? mem[rd_ptr][31:0] : 32'd0;
  assign out_err         = out_valid ? mem[rd_ptr][32]   : 1'b0;

  // FIFO storage: data is written on accept only and never reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= enc_p0;
  end

  // FIFO control: reset and flush take priority over any push or pop
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
    end
  end

  // Statistics: every accept counts, errored accepts saturate at 255
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      enc_count <= '0;
      err_count <= '0;
    end else if (push) begin
      enc_count <= enc_count + 16'd1;
      if (enc_p0[32]) err_count <= sat_inc8(err_count);
    end
  end

endmodule
